// File: rtl/vc_lru_ctrl_pkg.sv
// rtl/vc_lru_ctrl_pkg.sv - shared types and helpers for the victim-cache LRU controller
// Contents: controller state enum, index-width helper, default-size age type.
package vc_lru_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_WRITE  = 2'd2
   } state_t;

   // Entry index / age width for a given entry count (never narrower than 1 bit).
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int VC_SIZE_DFLT = 8;

   typedef logic [idx_w(VC_SIZE_DFLT)-1:0] age_t;

endpackage

// File: rtl/vc_lru_ctrl_if.sv
// rtl/vc_lru_ctrl_if.sv - request/response bundle between the L1 eviction path and the LRU controller
// Signals: valid_in, hit_en, hit_vec, insert_req (towards controller);
//          insert_ack, load, victim_idx, victim_was_valid, busy (from controller).
// Modports: master = requester side, slave = controller side.
interface vc_lru_ctrl_if
   import vc_lru_ctrl_pkg::*;
#(
   parameter int vc_size = 8
) ();
   localparam int IDX_W = idx_w(vc_size);

   logic [vc_size-1:0] valid_in;
   logic               hit_en;
   logic [vc_size-1:0] hit_vec;
   logic               insert_req;
   logic               insert_ack;
   logic [vc_size-1:0] load;
   logic [IDX_W-1:0]   victim_idx;
   logic               victim_was_valid;
   logic               busy;

   modport master (
      output valid_in, hit_en, hit_vec, insert_req,
      input  insert_ack, load, victim_idx, victim_was_valid, busy
   );

   modport slave (
      input  valid_in, hit_en, hit_vec, insert_req,
      output insert_ack, load, victim_idx, victim_was_valid, busy
   );
endinterface

// File: rtl/vc_lru_ctrl_victim_select.sv
// rtl/vc_lru_ctrl_victim_select.sv - combinational victim chooser
// Inputs:  valid_in (per-entry valid), age (per-entry LRU age, 0 = MRU).
// Outputs: victim_idx (lowest free entry, else the LRU entry), victim_was_valid.
module vc_lru_ctrl_victim_select
   import vc_lru_ctrl_pkg::*;
#(
   parameter  int vc_size = 8,
   localparam int IDX_W   = idx_w(vc_size)
) (
   input  logic [vc_size-1:0] valid_in,
   input  logic [IDX_W-1:0]   age [vc_size],
   output logic [IDX_W-1:0]   victim_idx,
   output logic               victim_was_valid
);

   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] lru_idx;
   logic             any_free;

   always_comb begin
      free_idx = '0;
      lru_idx  = '0;
      any_free = ~&valid_in;
      // Descending scan so the lowest free index wins.
      for (int i = vc_size - 1; i >= 0; i--) begin
         if (!valid_in[i]) begin
            free_idx = IDX_W'(i);
         end
      end
      // Ages are a permutation, so exactly one entry matches.
      for (int i = 0; i < vc_size; i++) begin
         if (age[i] == IDX_W'(vc_size - 1)) begin
            lru_idx = IDX_W'(i);
         end
      end
   end

   assign victim_idx       = any_free ? free_idx : lru_idx;
   assign victim_was_valid = valid_in[victim_idx];

endmodule

// File: rtl/vc_lru_ctrl.sv
// rtl/vc_lru_ctrl.sv - victim-cache true-LRU replacement and insert controller
// Ports: clk, rst (async, active-high),
//        bus (vc_lru_ctrl_if.slave): valid_in, hit_en, hit_vec, insert_req in;
//        insert_ack, load, victim_idx, victim_was_valid, busy out (all registered).
module vc_lru_ctrl
   import vc_lru_ctrl_pkg::*;
#(
   parameter  int vc_size = 8,
   localparam int IDX_W   = idx_w(vc_size)
) (
   input  logic          clk,
   input  logic          rst,
   vc_lru_ctrl_if.slave  bus
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   age_q [vc_size];
   logic [IDX_W-1:0]   age_d [vc_size];
   logic [IDX_W-1:0]   victim_idx_q, victim_idx_d;
   logic               was_valid_q, was_valid_d;
   logic [vc_size-1:0] load_q, load_d;
   logic               ack_q, ack_d;
   logic               busy_q, busy_d;

   logic [IDX_W-1:0]   sel_idx;
   logic               sel_was_valid;
   logic [IDX_W-1:0]   hit_idx;
   logic               hit_any;
   logic               touch_en;
   logic [IDX_W-1:0]   touch_idx;

   vc_lru_ctrl_victim_select #(
      .vc_size (vc_size)
   ) u_victim_select (
      .valid_in         (bus.valid_in),
      .age              (age_q),
      .victim_idx       (sel_idx),
      .victim_was_valid (sel_was_valid)
   );

   // Lowest set bit of hit_vec; multi-hot vectors resolve to the lowest entry.
   always_comb begin
      hit_idx = '0;
      hit_any = |bus.hit_vec;
      for (int i = vc_size - 1; i >= 0; i--) begin
         if (bus.hit_vec[i]) begin
            hit_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      victim_idx_d = victim_idx_q;
      was_valid_d  = was_valid_q;
      load_d       = '0;
      ack_d        = 1'b0;
      touch_en     = 1'b0;
      touch_idx    = victim_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.hit_en && hit_any) begin
               touch_en  = 1'b1;
               touch_idx = hit_idx;
            end
            if (bus.insert_req) begin
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: begin
            // Outputs are registered, so the WRITE-cycle pulses are prepared here.
            victim_idx_d = sel_idx;
            was_valid_d  = sel_was_valid;
            load_d       = {{(vc_size-1){1'b0}}, 1'b1} << sel_idx;
            ack_d        = 1'b1;
            state_d      = ST_WRITE;
         end
         ST_WRITE: begin
            touch_en  = 1'b1;
            touch_idx = victim_idx_q;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Touch: entries younger than the touched one age by one, touched entry becomes MRU.
   always_comb begin
      for (int j = 0; j < vc_size; j++) begin
         age_d[j] = age_q[j];
         if (touch_en && (age_q[j] < age_q[touch_idx])) begin
            age_d[j] = age_q[j] + 1'b1;
         end
      end
      if (touch_en) begin
         age_d[touch_idx] = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         victim_idx_q <= '0;
         was_valid_q  <= 1'b0;
         load_q       <= '0;
         ack_q        <= 1'b0;
         busy_q       <= 1'b0;
         for (int i = 0; i < vc_size; i++) begin
            age_q[i] <= IDX_W'(i);
         end
      end else begin
         state_q      <= state_d;
         victim_idx_q <= victim_idx_d;
         was_valid_q  <= was_valid_d;
         load_q       <= load_d;
         ack_q        <= ack_d;
         busy_q       <= busy_d;
         for (int i = 0; i < vc_size; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

   assign bus.insert_ack       = ack_q;
   assign bus.load             = load_q;
   assign bus.victim_idx       = victim_idx_q;
   assign bus.victim_was_valid = was_valid_q;
   assign bus.busy             = busy_q;

endmodule
